// File: rtl/ecg_fp_pkg.sv
// rtl/ecg_fp_pkg.sv - shared FP32 word type, constants and sequencer state encoding
package ecg_fp_pkg;
   localparam int DW            = 32;
   localparam int NTAPS_DEFAULT = 16;

   typedef logic [DW-1:0] fp32_t;

   localparam fp32_t FP32_ZERO = 32'h0000_0000;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - sample, coefficient and operand-pair links of the tap sequencer
interface fir_tap_sequencer_if
   import ecg_fp_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEFAULT,
   parameter int AW    = $clog2(NTAPS)
);
   logic          s_valid;
   fp32_t         s_data;
   logic          s_ready;
   logic          coef_we;
   logic [AW-1:0] coef_addr;
   fp32_t         coef_data;
   logic          coef_err;
   logic          m_valid;
   logic          m_ready;
   fp32_t         m_a;
   fp32_t         m_b;
   logic          m_first;
   logic          m_last;
   logic          busy;

   modport master (
      output s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
      input  s_ready, coef_err, m_valid, m_a, m_b, m_first, m_last, busy
   );

   modport slave (
      input  s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
      output s_ready, coef_err, m_valid, m_a, m_b, m_first, m_last, busy
   );
endinterface

// File: rtl/fir_delay_ram.sv
// rtl/fir_delay_ram.sv - circular sample delay line, one write port, one async read port
module fir_delay_ram
   import ecg_fp_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEFAULT,
   parameter int AW    = $clog2(NTAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fp32_t         wdata,
   input  logic [AW-1:0] raddr,
   output fp32_t         rdata
);
   fp32_t mem_q [NTAPS];
   fp32_t mem_d [NTAPS];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) mem_q[i] <= FP32_ZERO;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - streams (x[n-k], h[k]) operand pairs for each accepted FP32 sample
module fir_tap_sequencer
   import ecg_fp_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEFAULT,
   parameter int AW    = $clog2(NTAPS)
) (
   input  logic               clk,
   input  logic               rst_n,
   fir_tap_sequencer_if.slave bus
);
   localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] tap_q, tap_d;
   logic          m_valid_q, m_valid_d;
   fp32_t         m_a_q, m_a_d;
   fp32_t         m_b_q, m_b_d;
   logic          coef_err_q, coef_err_d;
   fp32_t         coef_q [NTAPS];
   fp32_t         coef_d [NTAPS];

   logic          accept;
   logic          hs;
   logic [AW-1:0] tap_nxt;
   logic [AW-1:0] rd_addr;
   fp32_t         rd_data;

   assign accept  = (state_q == ST_IDLE) && bus.s_valid;
   assign hs      = m_valid_q && bus.m_ready;
   assign tap_nxt = tap_q + 1'b1;
   // Prefetch address for the pair after the current one; wraps modulo NTAPS.
   assign rd_addr = base_q - tap_nxt;

   fir_delay_ram #(.NTAPS(NTAPS), .AW(AW)) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept),
      .waddr (wr_ptr_q),
      .wdata (bus.s_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      base_d     = base_q;
      tap_d      = tap_q;
      m_valid_d  = m_valid_q;
      m_a_d      = m_a_q;
      m_b_d      = m_b_q;
      coef_d     = coef_q;
      coef_err_d = 1'b0;

      if (bus.coef_we) begin
         if (state_q == ST_IDLE) coef_d[bus.coef_addr] = bus.coef_data;
         else                    coef_err_d = 1'b1;
      end

      if (state_q == ST_IDLE) begin
         if (bus.s_valid) begin
            // Tap 0 bypasses the RAM and sees the coefficient bank before any same-cycle write.
            state_d   = ST_ISSUE;
            base_d    = wr_ptr_q;
            tap_d     = '0;
            m_valid_d = 1'b1;
            m_a_d     = bus.s_data;
            m_b_d     = coef_q[0];
         end
      end else if (hs) begin
         if (tap_q == LAST_TAP) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            tap_d     = '0;
            wr_ptr_d  = wr_ptr_q + 1'b1;
         end else begin
            tap_d = tap_nxt;
            m_a_d = rd_data;
            m_b_d = coef_q[tap_nxt];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         base_q     <= '0;
         tap_q      <= '0;
         m_valid_q  <= 1'b0;
         m_a_q      <= FP32_ZERO;
         m_b_q      <= FP32_ZERO;
         coef_err_q <= 1'b0;
         for (int i = 0; i < NTAPS; i++) coef_q[i] <= FP32_ZERO;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         base_q     <= base_d;
         tap_q      <= tap_d;
         m_valid_q  <= m_valid_d;
         m_a_q      <= m_a_d;
         m_b_q      <= m_b_d;
         coef_err_q <= coef_err_d;
         coef_q     <= coef_d;
      end
   end

   assign bus.s_ready  = (state_q == ST_IDLE);
   assign bus.busy     = (state_q == ST_ISSUE);
   assign bus.m_valid  = m_valid_q;
   assign bus.m_a      = m_a_q;
   assign bus.m_b      = m_b_q;
   assign bus.m_first  = m_valid_q && (tap_q == '0);
   assign bus.m_last   = m_valid_q && (tap_q == LAST_TAP);
   assign bus.coef_err = coef_err_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;
   localparam int NT = 16;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        first;
      logic        last;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fir_tap_sequencer_if #(.NTAPS(NT)) bus ();

   fir_tap_sequencer #(.NTAPS(NT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] fbits [17];
   bit          pat [6];
   logic [31:0] hist [$];
   logic [31:0] mcoef [NT];
   logic [31:0] got_a [NT];
   logic [31:0] got_b [NT];
   logic        got_f [NT];
   logic        got_l [NT];
   vec_t        tbl [NT];
   logic [31:0] xs [13];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.m_ready   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
      for (int k = 0; k < NT; k++) mcoef[k] = 32'h0;
   endtask

   task automatic write_coef(input int k, input logic [31:0] v);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(k);
      bus.coef_data = v;
      @(negedge clk);
      bus.coef_we = 1'b0;
      chk("coef_err_idle_write", bus.coef_err, 1'b0);
      mcoef[k] = v;
   endtask

   // One sample burst: rmode 0=always ready, 1=fixed pattern, 2=random.
   task automatic burst(input logic [31:0] x, input int rmode,
                        input bit acc_we, input int acc_k, input logic [31:0] acc_v,
                        input bit bw, input bit chain, input logic [31:0] nx);
      logic [31:0] ea [NT];
      logic [31:0] eb [NT];
      logic [31:0] pa, pb;
      logic        pf, pl;
      int          n = 0;
      int          cyc = 0;
      int          ph = 0;
      int          bwst = 0;
      bit          stalled = 0;
      bit          rdy;

      while (!bus.s_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("s_ready_before_accept", bus.s_ready, 1'b1);

      hist.push_back(x);
      if (hist.size() > NT) void'(hist.pop_front());
      eb[0] = mcoef[0];
      if (acc_we) mcoef[acc_k] = acc_v;
      for (int k = 0; k < NT; k++) begin
         ea[k] = (k < hist.size()) ? hist[hist.size() - 1 - k] : 32'h0;
         if (k > 0) eb[k] = mcoef[k];
      end

      bus.s_valid   = 1'b1;
      bus.s_data    = x;
      bus.coef_we   = acc_we;
      bus.coef_addr = 4'(acc_k);
      bus.coef_data = acc_v;
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.coef_we = 1'b0;
      chk("first_pair_latency", bus.m_valid, 1'b1);
      chk("busy_in_burst", bus.busy, 1'b1);

      cyc = 0;
      while (n < NT && cyc < 200) begin
         if (bwst == 1) begin
            chk("coef_err_pulse", bus.coef_err, 1'b1);
            bus.coef_we = 1'b0;
            bwst = 2;
         end else if (bwst == 2) begin
            chk("coef_err_clear", bus.coef_err, 1'b0);
            bwst = 3;
         end
         chk("m_valid_in_burst", bus.m_valid, 1'b1);
         if (stalled) begin
            chk($sformatf("hold_a_tap%0d", n), bus.m_a, pa);
            chk($sformatf("hold_b_tap%0d", n), bus.m_b, pb);
            chk($sformatf("hold_first_tap%0d", n), bus.m_first, pf);
            chk($sformatf("hold_last_tap%0d", n), bus.m_last, pl);
         end
         pa = bus.m_a;
         pb = bus.m_b;
         pf = bus.m_first;
         pl = bus.m_last;
         rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[ph % 6] : 1'($urandom_range(0, 1));
         ph++;
         if (bw && n == 2 && bwst == 0) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 4'd3;
            bus.coef_data = 32'hDEAD_BEEF;
            bwst = 1;
         end
         bus.m_ready = rdy;
         if (rdy) begin
            chk($sformatf("tap%0d_a", n), bus.m_a, ea[n]);
            chk($sformatf("tap%0d_b", n), bus.m_b, eb[n]);
            chk($sformatf("tap%0d_first", n), bus.m_first, (n == 0));
            chk($sformatf("tap%0d_last", n), bus.m_last, (n == NT - 1));
            got_a[n] = bus.m_a;
            got_b[n] = bus.m_b;
            got_f[n] = bus.m_first;
            got_l[n] = bus.m_last;
            n++;
            stalled = 0;
            if (n == NT && chain) begin
               bus.s_valid = 1'b1;
               bus.s_data  = nx;
            end
         end else begin
            stalled = 1;
         end
         @(negedge clk);
         cyc++;
      end
      bus.m_ready = 1'b0;
      bus.coef_we = 1'b0;
      chk("burst_handshakes", n, NT);
      chk("m_valid_after_burst", bus.m_valid, 1'b0);
      chk("s_ready_after_burst", bus.s_ready, 1'b1);
      chk("busy_after_burst", bus.busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fbits = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000,
                32'h41880000};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < NT; k++)
         tbl[k] = '{a: (k == 0) ? 32'h3F800000 : 32'h0, b: fbits[k],
                    first: (k == 0), last: (k == NT - 1)};
      for (int i = 0; i < 13; i++) xs[i] = $urandom;

      idle_inputs();
      hist.delete();
      for (int k = 0; k < NT; k++) mcoef[k] = 32'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_s_ready", bus.s_ready, 1'b1);
      chk("reset_m_valid", bus.m_valid, 1'b0);
      chk("reset_m_a", bus.m_a, 32'h0);
      chk("reset_m_b", bus.m_b, 32'h0);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_coef_err", bus.coef_err, 1'b0);
      chk("reset_m_first", bus.m_first, 1'b0);
      chk("reset_m_last", bus.m_last, 1'b0);
      @(negedge clk);

      for (int k = 0; k < NT; k++) write_coef(k, fbits[k]);
      burst(32'h3F800000, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < NT; k++) begin
         chk($sformatf("impulse_a%0d", k), got_a[k], tbl[k].a);
         chk($sformatf("impulse_b%0d", k), got_b[k], tbl[k].b);
         chk($sformatf("impulse_first%0d", k), got_f[k], tbl[k].first);
         chk($sformatf("impulse_last%0d", k), got_l[k], tbl[k].last);
      end

      burst(32'h40000000, 1, 0, 0, 0, 0, 0, 0);

      burst(32'h40400000, 0, 0, 0, 0, 1, 0, 0);
      burst(32'h40800000, 2, 0, 0, 0, 0, 0, 0);
      chk("busy_write_dropped_b3", got_b[3], fbits[3]);

      burst(32'h40A00000, 0, 1, 0, 32'h1111_1111, 0, 0, 0);
      chk("accept_write_tap0_old", got_b[0], fbits[0]);
      burst(32'h40C00000, 0, 1, 5, 32'h2222_2222, 0, 0, 0);
      chk("accept_write_tap5_new", got_b[5], 32'h2222_2222);

      do_reset();
      for (int k = 0; k < NT; k++) write_coef(k, fbits[k]);
      for (int i = 0; i < 17; i++)
         burst(fbits[i], 2, 0, 0, 0, 0, (i < 16), (i < 16) ? fbits[(i + 1) % 17] : 32'h0);
      chk("wrap_tap0_a", got_a[0], 32'h41880000);
      chk("wrap_tap15_a", got_a[15], 32'h40000000);

      for (int r = 0; r < 12; r++)
         burst(xs[r], $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, NT - 1),
               $urandom, 0, (r < 11), xs[r + 1]);

      bus.s_valid = 1'b1;
      bus.s_data  = 32'h40E00000;
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      repeat (7) @(negedge clk);
      chk("midburst_valid_before_reset", bus.m_valid, 1'b1);
      rst_n = 1'b0;
      bus.m_ready = 1'b0;
      #1;
      chk("midburst_reset_m_valid", bus.m_valid, 1'b0);
      chk("midburst_reset_s_ready", bus.s_ready, 1'b1);
      chk("midburst_reset_busy", bus.busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
      for (int k = 0; k < NT; k++) mcoef[k] = 32'h0;
      burst(32'h40400000, 0, 0, 0, 0, 0, 0, 0);
      chk("post_reset_tap0_a", got_a[0], 32'h40400000);
      chk("post_reset_tap7_b", got_b[7], 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
